// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read interface between the fetch unit and a
// combinational instruction memory.
//   Address     : byte address driven by the fetch unit (word index = [8:2])
//   Instruction : instruction word returned for Address in the same cycle
// master = fetch unit side, slave = memory side.
interface instruction_fetch_unit_if;
  logic [31:0] Address;
  logic [31:0] Instruction;

  modport master (output Address, input Instruction);
  modport slave  (input Address, output Instruction);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage of the pipelined MIPS datapath.
// Owns the PC, drives the instruction-memory address and captures the
// returned word into the IF/ID pipeline register.
// Ports:
//   Clk, Reset          : clock, asynchronous active-low reset
//   Stall               : hold PC and IF/ID
//   Redirect,
//   RedirectTarget      : branch/jump redirect; flushes IF/ID for one slot
//   imem                : instruction-memory read interface (master)
//   PC                  : current fetch PC
//   Instruction_ID,
//   PCPlus4_ID,
//   Valid_ID            : IF/ID pipeline register
//   FetchCount          : instructions accepted into IF/ID (wraps)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Stall,
  input  logic                              Redirect,
  input  logic [31:0]                       RedirectTarget,
  instruction_fetch_unit_if.master          imem,
  output logic [31:0]                       PC,
  output logic [31:0]                       Instruction_ID,
  output logic [31:0]                       PCPlus4_ID,
  output logic                              Valid_ID,
  output logic [31:0]                       FetchCount
);

  logic [31:0] pc_plus4;

  assign pc_plus4     = PC + 32'd4;
  assign imem.Address = PC;

  // Redirect beats Stall beats normal advance. The if/else form keeps an
  // unknown control value from propagating X into the registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC             <= RESET_PC;
      Instruction_ID <= NOP_WORD;
      PCPlus4_ID     <= 32'd0;
      Valid_ID       <= 1'b0;
      FetchCount     <= 32'd0;
    end else if (Redirect) begin
      // Wrong-path word on imem.Instruction is dropped; a bubble goes in.
      PC             <= {RedirectTarget[31:2], 2'b00};
      Instruction_ID <= NOP_WORD;
      PCPlus4_ID     <= 32'd0;
      Valid_ID       <= 1'b0;
    end else if (Stall) begin
      PC             <= PC;
    end else begin
      PC             <= pc_plus4;
      Instruction_ID <= imem.Instruction;
      PCPlus4_ID     <= pc_plus4;
      Valid_ID       <= 1'b1;
      FetchCount     <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational
// 128-word instruction memory model.
module tb_instruction_fetch_unit;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] PC, Instruction_ID, PCPlus4_ID, FetchCount;
  logic        Valid_ID;
  logic [31:0] mem [128];
  int          checks = 0;
  int          errors = 0;

  instruction_fetch_unit_if bus();

  assign bus.Instruction = mem[bus.Address[8:2]];

  instruction_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .imem(bus), .PC(PC),
    .Instruction_ID(Instruction_ID), .PCPlus4_ID(PCPlus4_ID),
    .Valid_ID(Valid_ID), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[0]  = 32'h2008_0005;
    mem[5]  = 32'h2009_0004;
    mem[10] = 32'h0109_5020;
    Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'd0;

    // 1. Reset held for 3 edges
    step(3);
    chk("rst_pc",    PC,             32'h0);
    chk("rst_valid", {31'd0, Valid_ID}, 32'h0);
    chk("rst_instr", Instruction_ID, 32'h0);
    chk("rst_pc4",   PCPlus4_ID,     32'h0);
    chk("rst_cnt",   FetchCount,     32'h0);
    chk("rst_addr",  bus.Address,    32'h0);
    Reset = 1'b1;
    step();
    chk("e1_instr", Instruction_ID, 32'h2008_0005);
    chk("e1_pc4",   PCPlus4_ID,     32'h4);
    chk("e1_pc",    PC,             32'h4);
    chk("e1_cnt",   FetchCount,     32'd1);
    chk("e1_valid", {31'd0, Valid_ID}, 32'h1);

    // 2. Free run
    step(5);
    chk("e6_instr", Instruction_ID, 32'h2009_0004);
    chk("e6_pc",    PC,             32'h18);
    step(5);
    chk("e11_instr", Instruction_ID, 32'h0109_5020);
    chk("e11_pc4",   PCPlus4_ID,     32'h2C);
    chk("e11_cnt",   FetchCount,     32'd11);

    // 3. Stall at PC=8 (fresh reset)
    Reset = 1'b0; #1; Reset = 1'b1;
    step(2);
    chk("pre_stall_pc", PC, 32'h8);
    Stall = 1'b1;
    step(3);
    chk("stall_pc",   PC,          32'h8);
    chk("stall_addr", bus.Address, 32'h8);
    chk("stall_cnt",  FetchCount,  32'd2);
    chk("stall_pc4",  PCPlus4_ID,  32'h8);
    chk("stall_valid", {31'd0, Valid_ID}, 32'h1);
    Stall = 1'b0;
    step();
    chk("unstall_pc",  PC,         32'hC);
    chk("unstall_cnt", FetchCount, 32'd3);
    step();
    chk("pc_10", PC, 32'h10);

    // 4. Redirect to unaligned 0x17
    Redirect = 1'b1; RedirectTarget = 32'h17;
    step();
    chk("redir_pc",    PC,             32'h14);
    chk("redir_instr", Instruction_ID, 32'h0);
    chk("redir_valid", {31'd0, Valid_ID}, 32'h0);
    chk("redir_pc4",   PCPlus4_ID,     32'h0);
    chk("redir_cnt",   FetchCount,     32'd4);
    Redirect = 1'b0;
    step();
    chk("post_redir_instr", Instruction_ID, 32'h2009_0004);
    chk("post_redir_valid", {31'd0, Valid_ID}, 32'h1);
    chk("post_redir_cnt",   FetchCount,     32'd5);

    // 5. Redirect + Stall: redirect wins; then redirect to current PC
    Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h28;
    step();
    chk("rs_pc",    PC,         32'h28);
    chk("rs_valid", {31'd0, Valid_ID}, 32'h0);
    chk("rs_cnt",   FetchCount, 32'd5);
    Stall = 1'b0;
    step();
    chk("self_redir_pc",    PC,         32'h28);
    chk("self_redir_valid", {31'd0, Valid_ID}, 32'h0);
    Redirect = 1'b0;
    step();
    chk("b2b_instr", Instruction_ID, 32'h0109_5020);
    chk("b2b_pc",    PC,             32'h2C);
    chk("b2b_cnt",   FetchCount,     32'd6);

    // 6. Async reset mid-stall at PC=0x20
    Redirect = 1'b1; RedirectTarget = 32'h20;
    step();
    Redirect = 1'b0; Stall = 1'b1;
    step();
    chk("stall20_pc", PC, 32'h20);
    #2 Reset = 1'b0;
    #1;
    chk("async_pc",    PC,         32'h0);
    chk("async_valid", {31'd0, Valid_ID}, 32'h0);
    chk("async_cnt",   FetchCount, 32'h0);
    step();
    chk("hold_rst_pc", PC, 32'h0);
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFF;
    step();
    chk("top_pc",   PC,          32'hFFFF_FFFC);
    chk("top_addr", bus.Address, 32'hFFFF_FFFC);
    chk("top_cnt",  FetchCount,  32'd0);
    Redirect = 1'b0;
    step();
    chk("wrap_pc",    PC,             32'h0);
    chk("wrap_pc4",   PCPlus4_ID,     32'h0);
    chk("wrap_instr", Instruction_ID, 32'h0);
    chk("wrap_cnt",   FetchCount,     32'd1);

    // Unknown control inputs must leave state known
    Stall = 1'bx; Redirect = 1'b0;
    step();
    chk("x_known", {31'd0, $isunknown(PC) | $isunknown(FetchCount) | $isunknown(Valid_ID)}, 32'h0);
    Stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
